// File: rtl/gpc_pkg.sv
// Shared types and constants for the 3:2 GPC built-in self-test.
// Holds the BIST state encoding, GPC dimensions and drain length.
package gpc_pkg;

   localparam int GPC3_2_NIN   = 3;
   localparam int GPC3_2_NOUT  = 2;
   localparam int DRAIN_CYCLES = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_e;

   // Reference model for the GPC: unweighted count of ones in the input column.
   function automatic logic [GPC3_2_NOUT-1:0] popcount3(input logic [GPC3_2_NIN-1:0] v);
      logic [GPC3_2_NOUT-1:0] sum;
      sum = 2'd0;
      for (int i = 0; i < GPC3_2_NIN; i++) begin
         sum = sum + {1'b0, v[i]};
      end
      return sum;
   endfunction

endpackage

// File: rtl/gpc3_2.sv
// Combinational 3:2 generalized parallel counter (full-adder column).
// dst = number of ones in src0.
module gpc3_2
   import gpc_pkg::*;
(
   input  logic [GPC3_2_NIN-1:0]  src0,
   output logic [GPC3_2_NOUT-1:0] dst
);

   assign dst = {1'b0, src0[0]} + {1'b0, src0[1]} + {1'b0, src0[2]};

endmodule

// File: rtl/gpc3_2_bist.sv
// Exhaustive self-test of the gpc3_2 counter: sweeps all 8 inputs, captures the
// (optionally fault-injected) result, compares against a popcount and reports.
module gpc3_2_bist
   import gpc_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   inj_en,
   input  logic [1:0]             inj_mask,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [3:0]             err_cnt,
   output logic [2:0]             first_fail_vec,
   output logic [1:0]             first_fail_dst
);

   bist_state_e            state_q, state_d;
   logic [GPC3_2_NIN-1:0]  vec_q, vec_d;
   logic [1:0]             drain_q, drain_d;
   logic [GPC3_2_NIN-1:0]  cap_vec_q, cap_vec_d;
   logic [GPC3_2_NOUT-1:0] dst_q, dst_d;
   logic [GPC3_2_NOUT-1:0] exp_q, exp_d;
   logic                   val_q, val_d;
   logic [3:0]             err_cnt_q, err_cnt_d;
   logic [2:0]             ff_vec_q, ff_vec_d;
   logic [1:0]             ff_dst_q, ff_dst_d;
   logic [GPC3_2_NOUT-1:0] gpc_dst_s;
   logic                   mismatch_s;
   logic                   start_ok_s;

   gpc3_2 u_gpc (
      .src0 (vec_q),
      .dst  (gpc_dst_s)
   );

   assign mismatch_s = val_q && (dst_q != exp_q);
   assign start_ok_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      drain_d   = drain_q;
      cap_vec_d = cap_vec_q;
      dst_d     = dst_q;
      exp_d     = exp_q;
      val_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      ff_vec_d  = ff_vec_q;
      ff_dst_d  = ff_dst_q;

      // Compare stage runs one cycle behind capture; saturates at the vector count.
      if (mismatch_s) begin
         if (err_cnt_q != 4'd8) begin
            err_cnt_d = err_cnt_q + 4'd1;
         end else begin
            err_cnt_d = err_cnt_q;
         end
         if (err_cnt_q == 4'd0) begin
            ff_vec_d = cap_vec_q;
            ff_dst_d = dst_q;
         end else begin
            ff_vec_d = ff_vec_q;
            ff_dst_d = ff_dst_q;
         end
      end else begin
         err_cnt_d = err_cnt_q;
      end

      if (state_q == ST_RUN) begin
         cap_vec_d = vec_q;
         dst_d     = gpc_dst_s ^ (inj_en ? inj_mask : 2'b00);
         exp_d     = popcount3(vec_q);
         val_d     = 1'b1;
      end else begin
         val_d     = 1'b0;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok_s) begin
               state_d   = ST_RUN;
               vec_d     = 3'd0;
               err_cnt_d = 4'd0;
               ff_vec_d  = 3'd0;
               ff_dst_d  = 2'd0;
            end else begin
               state_d   = state_q;
            end
         end
         ST_RUN: begin
            if (vec_q == 3'd7) begin
               state_d = ST_DRAIN;
               drain_d = 2'(DRAIN_CYCLES - 1);
            end else begin
               vec_d   = vec_q + 3'd1;
            end
         end
         ST_DRAIN: begin
            if (drain_q == 2'd0) begin
               state_d = ST_DONE;
            end else begin
               drain_d = drain_q - 2'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, sweep counter, capture and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         vec_q     <= 3'd0;
         drain_q   <= 2'd0;
         cap_vec_q <= 3'd0;
         dst_q     <= 2'd0;
         exp_q     <= 2'd0;
         val_q     <= 1'b0;
         err_cnt_q <= 4'd0;
         ff_vec_q  <= 3'd0;
         ff_dst_q  <= 2'd0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         drain_q   <= drain_d;
         cap_vec_q <= cap_vec_d;
         dst_q     <= dst_d;
         exp_q     <= exp_d;
         val_q     <= val_d;
         err_cnt_q <= err_cnt_d;
         ff_vec_q  <= ff_vec_d;
         ff_dst_q  <= ff_dst_d;
      end
   end

   assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done           = (state_q == ST_DONE);
   assign pass           = (state_q == ST_DONE) && (err_cnt_q == 4'd0);
   assign err_cnt        = err_cnt_q;
   assign first_fail_vec = ff_vec_q;
   assign first_fail_dst = ff_dst_q;

endmodule

// File: tb/tb_gpc3_2_bist.sv
// Directed self-checking bench for gpc3_2_bist: clean, injected, reset and restart runs.
module tb_gpc3_2_bist;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       inj_en;
   logic [1:0] inj_mask;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_cnt;
   logic [2:0] first_fail_vec;
   logic [1:0] first_fail_dst;

   int n_checks = 0;
   int n_errors = 0;

   gpc3_2_bist dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .inj_en         (inj_en),
      .inj_mask       (inj_mask),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_cnt        (err_cnt),
      .first_fail_vec (first_fail_vec),
      .first_fail_dst (first_fail_dst)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges, settling 1 time unit after each.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulse start so it is sampled at edge E0; returns just after E0.
   task automatic kick();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic check_result(input string tag, input int e_pass, input int e_err,
                               input int e_vec, input int e_dst);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_pass"}, pass, e_pass);
      chk({tag, "_err"},  err_cnt, e_err);
      chk({tag, "_fvec"}, first_fail_vec, e_vec);
      chk({tag, "_fdst"}, first_fail_dst, e_dst);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; inj_en = 1'b0; inj_mask = 2'b00;
      step(2);
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err",  err_cnt, 0);

      // Clean run with per-cycle busy/done timeline.
      kick();
      for (int e = 1; e <= 10; e++) begin
         step(1);
         chk($sformatf("clean_busy_E%0d", e), busy, (e <= 9) ? 1 : 0);
         chk($sformatf("clean_done_E%0d", e), done, (e >= 10) ? 1 : 0);
      end
      check_result("clean", 1, 0, 0, 0);

      // Every vector corrupted in bit 0.
      inj_en = 1'b1; inj_mask = 2'b01;
      kick();
      step(9);
      chk("full_done_E9", done, 0);
      step(1);
      check_result("full", 0, 8, 0, 1);
      step(3);
      check_result("full_hold", 0, 8, 0, 1);

      // Restart from DONE clears counters at the restart edge.
      inj_en = 1'b0; inj_mask = 2'b00;
      kick();
      chk("b2b_clr_err",  err_cnt, 0);
      chk("b2b_clr_done", done, 0);
      chk("b2b_clr_fvec", first_fail_vec, 0);
      chk("b2b_clr_fdst", first_fail_dst, 0);
      chk("b2b_busy",     busy, 1);
      step(10);
      check_result("b2b", 1, 0, 0, 0);

      // Inject only while vector 5 is on the GPC input.
      kick();
      step(5);
      inj_en = 1'b1; inj_mask = 2'b10;
      step(1);
      inj_en = 1'b0; inj_mask = 2'b00;
      step(4);
      check_result("part", 0, 1, 5, 0);

      // Extra starts at E3 and E8 are ignored.
      kick();
      step(2);
      kick();
      step(4);
      kick();
      step(1);
      chk("ign_done_E9", done, 0);
      chk("ign_busy_E9", busy, 1);
      step(1);
      check_result("ign", 1, 0, 0, 0);

      // Reset mid-run at E4, with start asserted at the same edge.
      inj_en = 1'b1; inj_mask = 2'b11;
      kick();
      step(3);
      rst = 1'b1; start = 1'b1;
      step(1);
      rst = 1'b0; start = 1'b0;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_err",  err_cnt, 0);
      chk("mrst_fvec", first_fail_vec, 0);
      step(2);
      chk("mrst_idle", busy, 0);
      inj_en = 1'b0; inj_mask = 2'b00;
      kick();
      step(10);
      check_result("mrst_rerun", 1, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
